// File: rtl/mem_arb_pkg.sv
// Shared types for the single-port memory arbiter
// between the IF and MEM pipeline stages.
package mem_arb_pkg;
   typedef enum logic {IDLE, BUSY} stateT;
   typedef enum logic {OWN_IF, OWN_DM} ownerT;
   localparam logic [3:0] FETCH_BE = 4'hF;
endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times one memory access.
// Saturates at zero and flags it.
module mem_lat_counter
   import mem_arb_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] loadVal,
   input  logic         dec,
   output logic         zero
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= loadVal;
      end else if (dec && cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between fetch and
// load/store, stalling the pipeline until both are served.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [3:0]  dm_be,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        stall,
   output logic        mem_en,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

   stateT state, stateNext;
   ownerT owner, lastOwner, grantOwner;
   logic  ifDone, dmDone;
   logic  pendIf, pendDm, stallInt;
   logic  grant, finish, cntZero;

   assign pendIf   = if_req & ~ifDone;
   assign pendDm   = dm_req & ~dmDone;
   assign stallInt = pendIf | pendDm;
   assign stall    = stallInt & ~rst;

   mem_lat_counter #(.W(CW)) uCnt (
      .clk     (clk),
      .rst     (rst),
      .load    (grant),
      .loadVal (LOAD_VAL),
      .dec     (state == BUSY),
      .zero    (cntZero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext  = state;
      grant      = 1'b0;
      finish     = 1'b0;
      grantOwner = OWN_IF;
      unique case (state)
         IDLE: begin
            if (pendIf && pendDm) begin
               grant      = 1'b1;
               stateNext  = BUSY;
               grantOwner = (lastOwner == OWN_DM) ? OWN_IF : OWN_DM;
            end else if (pendIf || pendDm) begin
               grant      = 1'b1;
               stateNext  = BUSY;
               grantOwner = pendIf ? OWN_IF : OWN_DM;
            end
         end
         BUSY: begin
            if (cntZero) begin
               finish    = 1'b1;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= OWN_IF;
         lastOwner <= OWN_IF;
         ifDone    <= 1'b0;
         dmDone    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         if (grant) begin
            owner     <= grantOwner;
            lastOwner <= grantOwner;
            mem_en    <= 1'b1;
            if (grantOwner == OWN_IF) begin
               mem_we   <= 1'b0;
               mem_be   <= FETCH_BE;
               mem_addr <= if_addr;
            end else begin
               mem_we    <= dm_we;
               mem_be    <= dm_be;
               mem_addr  <= dm_addr;
               mem_wdata <= dm_wdata;
            end
         end
         if (finish) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (owner == OWN_IF) begin
               if_rdata <= mem_rdata;
            end else if (!mem_we) begin
               dm_rdata <= mem_rdata;
            end
         end
         // completion wins over the pipeline-advance clear
         ifDone <= (finish && owner == OWN_IF) || (ifDone && stallInt);
         dmDone <= (finish && owner == OWN_DM) || (dmDone && stallInt);
      end
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer for a single shared memory port between the instruction-fetch and data-memory stages of the five-stage pipeline. It accepts a fetch request from IF and a load/store request from MEM, grants one at a time, and drives a multi-cycle memory for exactly `MEM_LAT` cycles per access. It stalls the whole pipeline until every pending request has been served, and holds served results stable while the stall persists.

## Interface
- `MEM_LAT`, 2: memory access latency in cycles; must be at least 1.
- `clk  in  1`: clock.
- `rst  in  1`: synchronous, active-high reset.
- `if_req  in  1`: fetch request from the IF stage.
- `if_addr  in  32`: fetch address (PC).
- `if_rdata  out  32`: fetched instruction; valid once `if_done` is set.
- `dm_req  in  1`: load/store request from the MEM stage (EX/MEM MemRead | MemWrite).
- `dm_we  in  1`: 1 = store.
- `dm_be  in  4`: byte enables, already decoded from the MemWrBits field.
- `dm_addr  in  32`: data address (EX/MEM ALU result).
- `dm_wdata  in  32`: store data.
- `dm_rdata  out  32`: load data; valid once `dm_done` is set.
- `stall  out  1`: freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- `mem_en  out  1`: memory enable.
- `mem_we  out  1`: memory write enable.
- `mem_be  out  4`: memory byte enables.
- `mem_addr  out  32`: memory address.
- `mem_wdata  out  32`: memory write data.
- `mem_rdata  in  32`: memory read data, valid during the last cycle of an access.

## Operation
- **Internal state**
  - FSM with states IDLE and BUSY.
  - `owner` ∈ {IF, DM}.
  - `last_owner` register.
  - Down-counter `cnt`.
  - Sticky flags `if_done` and `dm_done`.
- **Pending terms**
  - `pend_if = if_req & ~if_done`
  - `pend_dm = dm_req & ~dm_done`
  - `stall = pend_if | pend_dm`, combinational, forced to 0 while `rst` is high.
- **IDLE**
  - Only one requester pending: grant it.
  - Both pending: grant IF if `last_owner` = DM, otherwise grant DM.
  - On grant:
    - Register `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` from the owner's inputs.
    - Fetches use `mem_we` = 0 and `mem_be` = 4'hF.
    - Set `mem_en` = 1, `cnt` = `MEM_LAT`−1, `owner`, `last_owner`.
    - Go to BUSY.
- **BUSY**
  - All `mem_*` outputs are held constant.
  - While `cnt` ≠ 0: decrement `cnt`.
  - When `cnt` = 0, at the closing edge:
    - Capture `mem_rdata` into `if_rdata` or `dm_rdata`; `dm_rdata` is left unchanged for stores.
    - Set the owner's done flag.
    - Set `mem_en` = 0, `mem_we` = 0.
    - Go to IDLE.
- **Back-to-back accesses**: every access is followed by at least one IDLE cycle.
- **Done flags**: both are cleared at any edge where `stall` = 0, i.e. when the pipeline advances.
- **Stores**: `mem_we` is held for the whole access. The memory commits the write once.
- **Requester contract**: the requester holds `req`, `addr`, `we`, `be` and `wdata` stable while pending. The arbiter samples them only at grant.
- **Boundary conditions**
  - **Request dropped mid-BUSY (flush)**: the access still completes and its done flag is set. The flag is cleared at the next non-stall edge.
  - **`req` high with done already set**: not pending. No new access is issued.
  - **`MEM_LAT` = 1**: exactly one BUSY cycle.
  - **`rst` in any state**: next state IDLE; all outputs and flags go to 0; `last_owner` = IF. An interrupted store has an undefined memory effect.

## Timing
- Reset values:
  - `mem_en`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` = 0.
  - `if_rdata`, `dm_rdata` = 0.
  - `stall` = 0.
  - `if_done`, `dm_done` = 0.
  - `last_owner` = IF, so DM wins the first conflict.
- Single access, request seen in IDLE at cycle 0:
  - BUSY during cycles 1..`MEM_LAT`.
  - Result and done flag visible from cycle `MEM_LAT`+1, where `stall` drops if nothing else is pending.
- Both pending at cycle 0:
  - Second access is BUSY during cycles `MEM_LAT`+2..2·`MEM_LAT`+1.
  - `stall` low at cycle 2·`MEM_LAT`+2.
- `stall` is combinational from the inputs and flags. All other outputs are registered.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum {IDLE, BUSY};
  - owner enum {OWN_IF, OWN_DM};
  - constant `FETCH_BE` = 4'hF.
- Counter width is `$clog2(MEM_LAT)` with a minimum of 1.
- One sub-module, `mem_lat_counter` (load, decrement, zero flag), is natural. The arbiter FSM, flags and output registers stay in `mem_port_arbiter`.

## Test plan
All scenarios use `MEM_LAT` = 2.
- **IF only**: `if_req` with `if_addr`=0x0000_3000; `mem_rdata`=0x2402_0005 in cycle 2 → `mem_en` high in cycles 1–2; `if_rdata`=0x2402_0005 and `stall`=0 in cycle 3.
- **Conflict after reset**: both requests at cycle 0, a load at 0x10 returning 0x0000_00AB → DM BUSY in cycles 1–2; `dm_rdata`=0xAB from cycle 3; IF BUSY in cycles 4–5; `stall` low at cycle 6; both done flags clear after that edge.
- **Store**: `dm_we`=1, `dm_be`=4'b0011, addr 0x20, `wdata`=0xDEAD_BEEF → `mem_we`=1, `mem_be`=0011, `mem_wdata`=0xDEAD_BEEF in cycles 1–2; `dm_rdata` keeps its prior value.
- **Fairness**: both pending again immediately after a round served DM→IF; `last_owner`=IF → DM is granted first again. Force `last_owner`=DM → IF is granted first.
- **Reset mid-access**: `rst` high in BUSY cycle 1 → next cycle IDLE, `mem_en`=0, `stall`=0, flags 0, all outputs 0.
- **Flush mid-access**: `if_req` dropped in BUSY cycle 1 → access completes, `if_done`=1 at cycle 3, `stall`=0, `if_done` cleared at cycle 4.
